// File: rtl/readout_pkg.sv
// Shared types and default widths for the post-run data-memory readout sequencer.
package readout_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/readout_addr_ctr.sv
// Loadable wrap-around read address plus remaining-word down-counter.
module readout_addr_ctr
    import readout_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   remaining_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            addr_reg      <= load_addr;
            remaining_reg <= load_count;
        end else if (step) begin
            remaining_reg <= remaining_reg - 1'b1;
            // The final word leaves the address parked on the last location read.
            if (!last)
                addr_reg <= addr_reg + 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = (remaining_reg == (ADDR_W+1)'(1));

endmodule

// File: rtl/mem_readout_ctrl.sv
// Takes over the data-memory port after a run and streams a contiguous
// address range out over a valid/ready handshake.
module mem_readout_ctrl
    import readout_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic [DATA_W-1:0] mem_data,
    output logic              hold,
    output logic [ADDR_W-1:0] inp_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    state_t state_reg, state_next;

    logic              hold_reg, hold_next;
    logic              out_valid_reg, out_valid_next;
    logic              busy_reg, done_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [ADDR_W-1:0] out_addr_reg;

    logic ctr_load, ctr_step, capture, last;
    logic handshake;

    readout_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load),
        .load_addr  (start_addr),
        .load_count (word_count),
        .step       (ctr_step),
        .addr       (inp_addr),
        .last       (last)
    );

    assign handshake = out_valid_reg & out_ready;

    always_comb begin
        state_next     = state_reg;
        ctr_load       = 1'b0;
        ctr_step       = 1'b0;
        capture        = 1'b0;
        hold_next      = hold_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        ctr_load   = 1'b1;
                        hold_next  = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_ISSUE:   state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                capture        = 1'b1;
                out_valid_next = 1'b1;
                state_next     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (handshake) begin
                    ctr_step       = 1'b1;
                    out_valid_next = 1'b0;
                    state_next     = last ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_FINISH: begin
                hold_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                hold_next      = 1'b0;
                out_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase

        // Abort overrides everything, but a simultaneous handshake still consumes the word.
        if (abort && state_reg != ST_IDLE) begin
            capture        = 1'b0;
            hold_next      = 1'b0;
            out_valid_next = 1'b0;
            state_next     = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            hold_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= (state_next != ST_IDLE);
            done_reg      <= (state_next == ST_FINISH);
            if (capture) begin
                out_data_reg <= mem_data;
                out_addr_reg <= inp_addr;
            end
        end
    end

    assign hold      = hold_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_addr  = out_addr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_mem_readout_ctrl.sv
// Directed bench for mem_readout_ctrl: table of dump scenarios plus abort and reset sequences.
module tb_mem_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [10:0] word_count = '0;
    logic        abort = 1'b0;
    logic [31:0] mem_data = '0;
    logic        hold;
    logic [9:0]  inp_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [9:0]  out_addr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];

    typedef struct {
        logic [9:0]       start_addr;
        logic [10:0]      word_count;
        int               stall_word;
        int               stall_cyc;
        logic [3:0][9:0]  exp_addr;
        logic [3:0][31:0] exp_data;
    } scen_t;

    scen_t tbl [4];

    mem_readout_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .mem_data   (mem_data),
        .hold       (hold),
        .inp_addr   (inp_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Data memory clocked on the inverted clock, like the datapath.
    always @(negedge clk) mem_data <= mem[inp_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_start(input logic [9:0] a, input logic [10:0] n);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for out_valid; returns the number of negedges waited.
    task automatic wait_valid(output int waited);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_valid: out_valid=0 after %0d cycles, expected 1", waited);
        end
    endtask

    task automatic run_scen(input int idx);
        scen_t s;
        int    waited;
        s = tbl[idx];
        issue_start(s.start_addr, s.word_count);
        if (s.word_count == 0) begin
            chk("zero_done", done, 1);
            chk("zero_hold", hold, 0);
            chk("zero_valid", out_valid, 0);
            $display("scen %0d: zero-length dump, done=%0b hold=%0b", idx, done, hold);
            @(negedge clk);
            chk("zero_done_fall", done, 0);
            chk("zero_busy_fall", busy, 0);
            chk("zero_hold_after", hold, 0);
            return;
        end
        chk("start_hold", hold, 1);
        chk("start_addr", inp_addr, s.start_addr);
        chk("start_busy", busy, 1);
        for (int i = 0; i < int'(s.word_count); i++) begin
            wait_valid(waited);
            chk("spacing", waited, 2);
            chk("out_addr", out_addr, s.exp_addr[i]);
            chk("out_data", out_data, s.exp_data[i]);
            chk("inp_addr", inp_addr, s.exp_addr[i]);
            chk("hold_mid", hold, 1);
            chk("done_mid", done, 0);
            $display("scen %0d word %0d: addr=%0d data=0x%0h", idx, i, out_addr, out_data);
            if (i == s.stall_word) begin
                out_ready = 1'b0;
                for (int c = 0; c < s.stall_cyc; c++) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, s.exp_data[i]);
                    chk("stall_addr", out_addr, s.exp_addr[i]);
                    chk("stall_inp", inp_addr, s.exp_addr[i]);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            chk("post_hs_valid", out_valid, 0);
            if (i == int'(s.word_count) - 1) begin
                chk("final_done", done, 1);
                chk("final_hold", hold, 1);
            end else begin
                chk("mid_done", done, 0);
            end
        end
        @(negedge clk);
        chk("after_done", done, 0);
        chk("after_hold", hold, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        int waited;
        for (int a = 0; a < 1024; a++) mem[a] = 32'hD000_0000 + a;
        mem[5] = 32'hA;
        mem[6] = 32'hB;
        mem[7] = 32'hC;

        tbl[0] = '{10'd5, 11'd3, -1, 0,
                   {10'd0, 10'd7, 10'd6, 10'd5},
                   {32'h0, 32'hC, 32'hB, 32'hA}};
        tbl[1] = '{10'd5, 11'd3, 1, 4,
                   {10'd0, 10'd7, 10'd6, 10'd5},
                   {32'h0, 32'hC, 32'hB, 32'hA}};
        tbl[2] = '{10'd1022, 11'd4, -1, 0,
                   {10'd1, 10'd0, 10'd1023, 10'd1022},
                   {32'hD000_0001, 32'hD000_0000, 32'hD000_03FF, 32'hD000_03FE}};
        tbl[3] = '{10'd0, 11'd0, -1, 0, '0, '0};

        #12;
        chk("rst_hold", hold, 0);
        chk("rst_inp_addr", inp_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 4; t++) run_scen(t);

        // Abort in PRESENT of word 2 of 5.
        issue_start(10'd100, 11'd5);
        wait_valid(waited);
        chk("abort_w0_addr", out_addr, 100);
        @(negedge clk);
        wait_valid(waited);
        chk("abort_w1_addr", out_addr, 101);
        chk("abort_w1_data", out_data, 32'hD000_0065);
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_hold", hold, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_done", done, 0);
        $display("abort: busy=%0b hold=%0b valid=%0b done=%0b", busy, hold, out_valid, done);
        @(negedge clk);
        chk("abort_done_later", done, 0);
        chk("abort_busy_later", busy, 0);
        run_scen(0);

        // Asynchronous reset while in CAPTURE.
        issue_start(10'd200, 11'd2);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_hold", hold, 0);
        chk("arst_inp_addr", inp_addr, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", out_data, 0);
        chk("arst_addr", out_addr, 0);
        $display("async reset: hold=%0b busy=%0b inp_addr=%0d", hold, busy, inp_addr);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_hold", hold, 0);
        chk("post_rst_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
